// File: rtl/dmem_wait_responder.sv
// Data-memory responder with a valid/ready request/response handshake and a fixed number of wait states.
// Serves one word access at a time from an internal RAM, flagging misaligned or out-of-range addresses.
module dmem_wait_responder #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned WAIT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int unsigned IW        = $clog2(DEPTH);
   localparam int unsigned CW        = 4;
   localparam bit          ZERO_WAIT = (WAIT == 0);
   localparam logic [CW-1:0] CNT_LOAD = ZERO_WAIT ? '0 : CW'(WAIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic          lat_write;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic [31:0]   mem [DEPTH];

   logic          accept_c;
   logic          exec_c;
   logic          ex_write_c;
   logic          ex_err_c;
   logic [31:0]   ex_addr_c;
   logic [31:0]   ex_wdata_c;
   logic [IW-1:0] ex_idx_c;

   // With no wait states the access executes on the accepting edge, so it must use the live inputs.
   always_comb begin
      accept_c   = (state == S_IDLE) && req_valid;
      exec_c     = (accept_c && ZERO_WAIT) || ((state == S_WAIT) && (cnt == '0));
      ex_write_c = (state == S_IDLE) ? req_write : lat_write;
      ex_addr_c  = (state == S_IDLE) ? req_addr  : lat_addr;
      ex_wdata_c = (state == S_IDLE) ? req_wdata : lat_wdata;
      ex_err_c   = (ex_addr_c[1:0] != 2'b00) || (ex_addr_c[31:2] >= 30'(DEPTH));
      ex_idx_c   = ex_addr_c[IW+1:2];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req_valid) state_nxt = ZERO_WAIT ? S_RESP : S_WAIT;
         S_WAIT:  if (cnt == '0) state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == S_IDLE);
      busy      = (state != S_IDLE);
      rsp_valid = (state == S_RESP);
   end

   // Request latch, wait counter and response registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept_c) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= CNT_LOAD;
         end else if ((state == S_WAIT) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
         end
         if (exec_c) begin
            rsp_err   <= ex_err_c;
            rsp_rdata <= (ex_err_c || ex_write_c) ? 32'h0 : mem[ex_idx_c];
         end
      end
   end

   // RAM contents survive reset; a store only commits on an error-free execute.
   always_ff @(posedge clk) begin
      if (!reset && exec_c && ex_write_c && !ex_err_c) mem[ex_idx_c] <= ex_wdata_c;
   end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder: three instances (WAIT = 2, 0, 3) sharing request signals,
// selected per transaction; checks data, error flag, latency and handshake timing.
module tb_dmem_wait_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        vld [3];
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_ready;

   logic        rr [3];
   logic        rv [3];
   logic [31:0] rd [3];
   logic        re [3];
   logic        bz [3];

   int          sel = 0;
   logic        rr_m, rv_m, re_m, bz_m;
   logic [31:0] rd_m;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dmem_wait_responder #(.DEPTH(64), .WAIT(2)) u_w2 (
      .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(rr[0]), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[0]), .rsp_ready(rsp_ready),
      .rsp_rdata(rd[0]), .rsp_err(re[0]), .busy(bz[0]));

   dmem_wait_responder #(.DEPTH(64), .WAIT(0)) u_w0 (
      .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(rr[1]), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[1]), .rsp_ready(rsp_ready),
      .rsp_rdata(rd[1]), .rsp_err(re[1]), .busy(bz[1]));

   dmem_wait_responder #(.DEPTH(64), .WAIT(3)) u_w3 (
      .clk(clk), .reset(reset), .req_valid(vld[2]), .req_ready(rr[2]), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[2]), .rsp_ready(rsp_ready),
      .rsp_rdata(rd[2]), .rsp_err(re[2]), .busy(bz[2]));

   always_comb begin
      rr_m = rr[sel];
      rv_m = rv[sel];
      rd_m = rd[sel];
      re_m = re[sel];
      bz_m = bz[sel];
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // One transaction on instance s; called just after a falling edge, returns just after a falling edge.
   task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdata, output logic err, output int lat,
                      output logic rr_acc, output logic rr_rsp);
      sel       = s;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      vld[s]    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vld[s] = 1'b0;
      rr_acc = rr_m;
      lat    = 1;
      while (!rv_m && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rdata  = rd_m;
      err    = re_m;
      rr_rsp = rr_m;
      if (rsp_ready) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   typedef struct {
      string       nm;
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl [14];

   initial begin
      logic [31:0] rdata;
      logic        err, rr_acc, rr_rsp;
      int          lat;

      tbl[0]  = '{"st_60",       1'b1, 32'h0000_0060, 32'hDEAD_BEEF, 32'h0, 1'b0};
      tbl[1]  = '{"ld_64",       1'b0, 32'h0000_0064, 32'h0,         32'h7, 1'b0};
      tbl[2]  = '{"ld_60",       1'b0, 32'h0000_0060, 32'h0,         32'hDEAD_BEEF, 1'b0};
      tbl[3]  = '{"st_mis_62",   1'b1, 32'h0000_0062, 32'h55,        32'h0, 1'b1};
      tbl[4]  = '{"ld_60_keep",  1'b0, 32'h0000_0060, 32'h0,         32'hDEAD_BEEF, 1'b0};
      tbl[5]  = '{"ld_oor_100",  1'b0, 32'h0000_0100, 32'h0,         32'h0, 1'b1};
      tbl[6]  = '{"st_last_fc",  1'b1, 32'h0000_00FC, 32'hA5A5,      32'h0, 1'b0};
      tbl[7]  = '{"ld_last_fc",  1'b0, 32'h0000_00FC, 32'h0,         32'hA5A5, 1'b0};
      tbl[8]  = '{"st_00",       1'b1, 32'h0000_0000, 32'h1357,      32'h0, 1'b0};
      tbl[9]  = '{"st_oor_100",  1'b1, 32'h0000_0100, 32'hFFFF,      32'h0, 1'b1};
      tbl[10] = '{"st_oor_hi",   1'b1, 32'h4000_0000, 32'hEEEE,      32'h0, 1'b1};
      tbl[11] = '{"ld_00_nowrap",1'b0, 32'h0000_0000, 32'h0,         32'h1357, 1'b0};
      tbl[12] = '{"ld_oor_top",  1'b0, 32'h8000_0000, 32'h0,         32'h0, 1'b1};
      tbl[13] = '{"ld_mis_61",   1'b0, 32'h0000_0061, 32'h0,         32'h0, 1'b1};

      reset     = 1'b1;
      vld[0]    = 1'b0;
      vld[1]    = 1'b0;
      vld[2]    = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("rst_req_ready", 32'(rr_m), 32'h1);
      check("rst_rsp_valid", 32'(rv_m), 32'h0);
      check("rst_busy",      32'(bz_m), 32'h0);
      check("rst_rdata",     rd_m,      32'h0);
      check("rst_err",       32'(re_m), 32'h0);

      // WAIT=2 store: ready drops after accept, response in 3rd cycle
      txn(0, 1'b1, 32'h64, 32'h7, rdata, err, lat, rr_acc, rr_rsp);
      check("w2_st_ready_after_acc", 32'(rr_acc), 32'h0);
      check("w2_st_latency",         32'(lat),    32'h3);
      check("w2_st_rdata",           rdata,       32'h0);
      check("w2_st_err",             32'(err),    32'h0);
      check("w2_idle_after_hs",      32'(rr_m),   32'h1);

      for (int i = 0; i < 14; i++) begin
         txn(0, tbl[i].w, tbl[i].a, tbl[i].d, rdata, err, lat, rr_acc, rr_rsp);
         check({tbl[i].nm, "_rdata"}, rdata,     tbl[i].exp_rd);
         check({tbl[i].nm, "_err"},   32'(err),  32'(tbl[i].exp_err));
         check({tbl[i].nm, "_lat"},   32'(lat),  32'h3);
      end

      // Back-pressure: response held for 5 cycles
      rsp_ready = 1'b0;
      txn(0, 1'b0, 32'h60, 32'h0, rdata, err, lat, rr_acc, rr_rsp);
      check("bp_first_rdata", rdata, 32'hDEAD_BEEF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", 32'(rv_m), 32'h1);
         check("bp_hold_rdata", rd_m,      32'hDEAD_BEEF);
         check("bp_hold_ready", 32'(rr_m), 32'h0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", 32'(rv_m), 32'h0);
      check("bp_release_ready", 32'(rr_m), 32'h1);
      check("bp_release_busy",  32'(bz_m), 32'h0);
      check("bp_rdata_kept",    rd_m,      32'hDEAD_BEEF);

      // WAIT=0 back-to-back store then load
      txn(1, 1'b1, 32'h04, 32'h11, rdata, err, lat, rr_acc, rr_rsp);
      check("w0_st_latency",     32'(lat),    32'h1);
      check("w0_st_ready_rsp",   32'(rr_rsp), 32'h0);
      check("w0_st_err",         32'(err),    32'h0);
      txn(1, 1'b0, 32'h04, 32'h0, rdata, err, lat, rr_acc, rr_rsp);
      check("w0_ld_latency",     32'(lat),    32'h1);
      check("w0_ld_ready_rsp",   32'(rr_rsp), 32'h0);
      check("w0_ld_rdata",       rdata,       32'h11);

      // WAIT=3: reset one cycle after accepting a store aborts it
      txn(2, 1'b1, 32'h08, 32'h1234, rdata, err, lat, rr_acc, rr_rsp);
      check("w3_pre_st_latency", 32'(lat), 32'h4);
      sel       = 2;
      req_write = 1'b1;
      req_addr  = 32'h08;
      req_wdata = 32'h99;
      vld[2]    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vld[2] = 1'b0;
      check("w3_busy_in_wait", 32'(bz_m), 32'h1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("w3_rst_busy",      32'(bz_m), 32'h0);
      check("w3_rst_rsp_valid", 32'(rv_m), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      txn(2, 1'b0, 32'h08, 32'h0, rdata, err, lat, rr_acc, rr_rsp);
      check("w3_ld_after_abort", rdata,     32'h1234);
      check("w3_ld_latency",     32'(lat),  32'h4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
